// File: rtl/sr_write_sequencer_if.sv
// sr_write_sequencer_if: config-word handshake and shift-engine signals between sequencer and environment
interface sr_write_sequencer_if #(
    parameter int WIDTH = 170
);
    logic [WIDTH-1:0] cfg_din;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] sr_din;
    logic             sr_start;
    logic             sr_load;
    logic             sr_clk;
    logic             sr_dout;

    modport master (
        input  cfg_din, cfg_valid, sr_load, sr_clk, sr_dout,
        output cfg_ready, sr_din, sr_start
    );

    modport slave (
        output cfg_din, cfg_valid, sr_load, sr_clk, sr_dout,
        input  cfg_ready, sr_din, sr_start
    );
endinterface

// File: rtl/sr_write_sequencer.sv
// sr_write_sequencer: shift-register config write with read-back verify, retry and watchdog
module sr_write_sequencer #(
    parameter int WIDTH       = 170,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_write_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [3:0]           retries
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, WR_START, WR_WAIT, RD_START, RD_CAPTURE, RD_WAIT, CHECK, DONE
    } state_t;

    state_t           state, nxt;
    logic             sr_clk_q;
    logic [WIDTH-1:0] capture;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    wd_cnt;
    logic             accept, sr_edge, last_bit, wd_hit, in_wait, match, can_retry, wd_abort, retry;

    assign accept    = bus.cfg_valid & bus.cfg_ready;
    assign sr_edge   = bus.sr_clk & ~sr_clk_q;
    assign last_bit  = sr_edge && bit_cnt == CW'(WIDTH - 1);
    assign wd_hit    = wd_cnt == TW'(TIMEOUT_CYC - 1);
    assign in_wait   = state inside {WR_WAIT, RD_CAPTURE, RD_WAIT};
    assign match     = bit_cnt == CW'(WIDTH) && capture == bus.sr_din;
    assign can_retry = retries < 4'(MAX_RETRY);
    assign wd_abort  = in_wait && nxt == DONE;
    assign retry     = state == CHECK && nxt == WR_START;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next state: engine completion beats a coincident watchdog expiry
    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = accept ? WR_START : IDLE;
            WR_START:   nxt = WR_WAIT;
            WR_WAIT:    nxt = bus.sr_load ? RD_START : wd_hit ? DONE : WR_WAIT;
            RD_START:   nxt = RD_CAPTURE;
            RD_CAPTURE: nxt = bus.sr_load ? CHECK : last_bit ? RD_WAIT : wd_hit ? DONE : RD_CAPTURE;
            RD_WAIT:    nxt = bus.sr_load ? CHECK : wd_hit ? DONE : RD_WAIT;
            CHECK:      nxt = (match || !can_retry) ? DONE : WR_START;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    // read-back capture: MSB-first serial data lands so the first bit ends up in capture[WIDTH-1]
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_clk_q <= 1'b0;
            capture  <= '0;
            bit_cnt  <= '0;
        end else begin
            sr_clk_q <= bus.sr_clk;
            if (state == RD_START) begin
                capture <= '0;
                bit_cnt <= '0;
            end else if (state == RD_CAPTURE && sr_edge && bit_cnt != CW'(WIDTH)) begin
                capture <= {capture[WIDTH-2:0], bus.sr_dout};
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    // watchdog: restarts on every state change, so it times each wait state from its entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_cnt <= '0;
        else      wd_cnt <= (nxt != state) ? '0 : wd_cnt + TW'(1);
    end

    // registered handshake, engine and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cfg_ready <= 1'b1;
            bus.sr_din    <= '0;
            bus.sr_start  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            retries       <= '0;
        end else begin
            bus.cfg_ready <= nxt == IDLE;
            bus.sr_din    <= accept ? bus.cfg_din : bus.sr_din;
            bus.sr_start  <= state == WR_START || state == RD_START;
            busy          <= nxt != IDLE;
            done          <= nxt == DONE;
            pass          <= accept ? 1'b0 : state == CHECK ? match : wd_abort ? 1'b0 : pass;
            timeout       <= accept ? 1'b0 : wd_abort ? 1'b1 : timeout;
            retries       <= accept ? 4'd0 : retry ? retries + 4'd1 : retries;
        end
    end
endmodule

// File: tb/tb_sr_write_sequencer.sv
// tb_sr_write_sequencer: directed and randomized checks against a behavioural engine and outcome model
module tb_sr_write_sequencer;
    localparam int W      = 170;
    localparam int MR     = 3;
    localparam int WD_CYC = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sr_write_sequencer_if #(.WIDTH(W)) bus ();
    sr_write_sequencer_if #(.WIDTH(W)) wd_bus ();

    logic       busy, done, pass, timeout;
    logic [3:0] retries;
    logic       wd_busy, wd_done, wd_pass, wd_timeout;
    logic [3:0] wd_retries;

    sr_write_sequencer #(.WIDTH(W), .MAX_RETRY(MR), .TIMEOUT_CYC(4096)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .retries(retries)
    );

    sr_write_sequencer #(.WIDTH(W), .MAX_RETRY(MR), .TIMEOUT_CYC(WD_CYC)) dut_wd (
        .clk(clk), .rst(rst), .bus(wd_bus), .busy(wd_busy), .done(wd_done),
        .pass(wd_pass), .timeout(wd_timeout), .retries(wd_retries)
    );

    int           tests = 0;
    int           fails = 0;
    int           n_start = 0;
    int           base = 0;
    int           e_corrupt = 0;
    int           e_flip = 0;
    bit           e_stuck = 1'b0;
    int           e_short = 0;
    logic [W-1:0] content = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // engine model: each pass shifts out its previous content MSB first, then latches the new word
    task automatic engine_pass();
        logic [W-1:0] rb;
        int k;
        int nedge;
        n_start++;
        k = n_start - base;
        rb = e_stuck ? '0 : content;
        nedge = W;
        if (k % 2 == 0) begin
            if (k / 2 <= e_corrupt) rb[e_flip] = ~rb[e_flip];
            if (e_short > 0) nedge = e_short;
        end
        for (int i = 0; i < nedge; i++) begin
            bus.sr_dout = rb[W-1-i];
            bus.sr_clk = 1'b1;
            @(negedge clk);
            bus.sr_clk = 1'b0;
            if (!rst) return;
            @(negedge clk);
            if (!rst) return;
        end
        content = bus.sr_din;
        bus.sr_load = 1'b1;
        @(negedge clk);
        bus.sr_load = 1'b0;
    endtask

    initial begin : engine
        bus.sr_load = 1'b0;
        bus.sr_clk  = 1'b0;
        bus.sr_dout = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bus.sr_start === 1'b1) engine_pass();
        end
    end

    task automatic start_op(input string tag, input logic [W-1:0] word);
        base = n_start;
        bus.cfg_din = word;
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        checkn({tag, " busy_on_accept"}, 32'(busy), 1);
        checkn({tag, " ready_on_accept"}, 32'(bus.cfg_ready), 0);
        checkn({tag, " start_lag"}, 32'(bus.sr_start), 0);
        @(negedge clk);
        checkn({tag, " start_pulse"}, 32'(bus.sr_start), 1);
    endtask

    // outcome model: attempt a verifies cleanly iff it is past the corrupted verifies and the read is whole
    task automatic finish_op(input string tag, input logic [W-1:0] word);
        int cyc;
        bit ep;
        int er;
        ep = e_short == 0 && e_corrupt <= MR && !(e_stuck && word != '0);
        er = ep ? e_corrupt : MR;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checkn({tag, " done_seen"}, 32'(done), 1);
        checkn({tag, " pass"}, 32'(pass), 32'(ep));
        checkn({tag, " retries"}, 32'(retries), 32'(er));
        checkn({tag, " timeout"}, 32'(timeout), 0);
        checkn({tag, " starts"}, 32'(n_start - base), 32'(2 * (er + 1)));
        checkn({tag, " busy_at_done"}, 32'(busy), 1);
        checkn({tag, " ready_at_done"}, 32'(bus.cfg_ready), 0);
        check({tag, " sr_din"}, bus.sr_din, word);
        @(negedge clk);
        checkn({tag, " done_width"}, 32'(done), 0);
        checkn({tag, " ready_after"}, 32'(bus.cfg_ready), 1);
        checkn({tag, " busy_after"}, 32'(busy), 0);
        checkn({tag, " pass_held"}, 32'(pass), 32'(ep));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] word, input int corrupt,
                          input int flip, input bit stuck, input int short_n);
        e_corrupt = corrupt;
        e_flip = flip;
        e_stuck = stuck;
        e_short = short_n;
        start_op(tag, word);
        finish_op(tag, word);
    endtask

    task automatic check_reset_values(input string tag);
        checkn({tag, " cfg_ready"}, 32'(bus.cfg_ready), 1);
        check({tag, " sr_din"}, bus.sr_din, '0);
        checkn({tag, " sr_start"}, 32'(bus.sr_start), 0);
        checkn({tag, " busy"}, 32'(busy), 0);
        checkn({tag, " done"}, 32'(done), 0);
        checkn({tag, " pass"}, 32'(pass), 0);
        checkn({tag, " timeout"}, 32'(timeout), 0);
        checkn({tag, " retries"}, 32'(retries), 0);
    endtask

    initial begin : stimulus
        logic [W-1:0] w_nom;
        logic [W-1:0] w;
        logic [W-1:0] w2;
        int cyc;
        int extra;
        int m;
        w_nom = {1'b1, 169'b1011};
        bus.cfg_din = '0;
        bus.cfg_valid = 1'b0;
        wd_bus.cfg_din = '0;
        wd_bus.cfg_valid = 1'b0;
        wd_bus.sr_load = 1'b0;
        wd_bus.sr_clk = 1'b0;
        wd_bus.sr_dout = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        run_op("nominal", w_nom, 0, 0, 1'b0, 0);
        run_op("corrupt1", w_nom, 1, 0, 1'b0, 0);
        run_op("stuck0", w_nom, 0, 0, 1'b1, 0);
        run_op("short100", w_nom, 0, 0, 1'b0, 100);

        wd_bus.cfg_din = w_nom;
        wd_bus.cfg_valid = 1'b1;
        @(negedge clk);
        wd_bus.cfg_valid = 1'b0;
        @(negedge clk);
        checkn("wd start_pulse", 32'(wd_bus.sr_start), 1);
        cyc = 0;
        extra = 0;
        while (wd_done !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (wd_bus.sr_start === 1'b1) extra++;
        end
        checkn("wd latency", 32'(cyc), WD_CYC);
        checkn("wd timeout", 32'(wd_timeout), 1);
        checkn("wd pass", 32'(wd_pass), 0);
        checkn("wd retries", 32'(wd_retries), 0);
        checkn("wd extra_starts", 32'(extra), 0);
        @(negedge clk);
        checkn("wd done_width", 32'(wd_done), 0);
        checkn("wd ready_after", 32'(wd_bus.cfg_ready), 1);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < W; j++) w[j] = 1'($urandom_range(0, 1));
            m = int'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", r), w,
                   m == 1 ? int'($urandom_range(1, 5)) : 0,
                   int'($urandom_range(0, W - 1)),
                   m == 2,
                   m == 3 ? int'($urandom_range(1, W - 1)) : 0);
        end

        e_corrupt = 0;
        e_flip = 0;
        e_stuck = 1'b0;
        e_short = 0;
        for (int j = 0; j < W; j++) w[j] = 1'($urandom_range(0, 1));
        for (int j = 0; j < W; j++) w2[j] = 1'($urandom_range(0, 1));
        base = n_start;
        bus.cfg_din = w;
        bus.cfg_valid = 1'b1;
        cyc = 0;
        while (n_start - base < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkn("rst reached_read", 32'(n_start - base), 2);
        repeat (40) @(negedge clk);
        bus.cfg_din = w2;
        rst = 1'b0;
        #1;
        check_reset_values("rst async");
        repeat (2) begin
            @(negedge clk);
            checkn("rst no_done", 32'(done), 0);
        end
        base = n_start;
        rst = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        checkn("rst reaccept busy", 32'(busy), 1);
        check("rst reaccept sr_din", bus.sr_din, w2);
        @(negedge clk);
        checkn("rst reaccept start", 32'(bus.sr_start), 1);
        finish_op("rst_restart", w2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sr_write_sequencer.md
# sr_write_sequencer

Sequences a serial configuration shift-register write with read-back verification. It sits between the configuration register file and the SR_Control shift engine. For each accepted word it issues a write pass, then a second identical pass during which the previous content shifts out on the engine's serial output. It captures that read-back, compares it against the written word, retries on mismatch, and reports pass/fail/timeout.

## Interface
Parameters:
- WIDTH, 170, shift-register length in bits.
- MAX_RETRY, 3, extra write+verify attempts after the first failed compare (range 0..15).
- TIMEOUT_CYC, 4096, maximum clk cycles allowed in any wait state.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_din  in  WIDTH  configuration word.
- cfg_valid  in  1  word offered.
- cfg_ready  out  1  high only in IDLE; transfer on cfg_valid & cfg_ready.
- sr_din  out  WIDTH  word driven to the engine; held stable from accept until DONE.
- sr_start  out  1  one-cycle start pulse to the engine.
- sr_load  in  1  engine completion pulse (load_sr), one clk wide.
- sr_clk  in  1  engine shift clock (clk_sr), synchronous to clk.
- sr_dout  in  1  engine serial read-back (data_out).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an operation ends.
- pass  out  1  result of the last operation; valid from done until the next accept.
- timeout  out  1  last operation aborted by the watchdog; same validity as pass.
- retries  out  4  attempts beyond the first, used by the last operation.

## Operation
- States: IDLE, WR_START, WR_WAIT, RD_START, RD_CAPTURE, RD_WAIT, CHECK, DONE.
- IDLE: on handshake, latch cfg_din into sr_din, clear retries, pass and timeout, and go to WR_START.
- WR_START: assert sr_start for one cycle, then go to WR_WAIT.
- WR_WAIT: wait for sr_load, then go to RD_START.
- RD_START: clear the capture register and the bit counter, pulse sr_start, then go to RD_CAPTURE.
- RD_CAPTURE:
  - Detect sr_clk rising edges using a registered copy of sr_clk.
  - On each edge, shift sr_dout into the LSB of the capture register and increment the bit counter. The counter is $clog2(WIDTH+1) bits wide.
  - The first captured bit corresponds to sr_din[WIDTH-1].
  - When the count reaches WIDTH, go to RD_WAIT. Edges beyond WIDTH are ignored.
- RD_WAIT: wait for sr_load, then go to CHECK.
  - If sr_load arrives in RD_CAPTURE before WIDTH bits are captured, go to CHECK immediately. This forces a mismatch.
- CHECK:
  - If the full count is reached and capture == sr_din: set pass=1 and go to DONE.
  - Else if retries < MAX_RETRY: increment retries and go to WR_START.
  - Else: set pass=0 and go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- Watchdog:
  - The cycle counter clears on entry to WR_WAIT, RD_CAPTURE and RD_WAIT.
  - If it reaches TIMEOUT_CYC in any of these states, set timeout=1 and pass=0, then go to DONE. No retry follows a timeout.
- cfg_valid outside IDLE is ignored; the word is not queued.
- An sr_load arriving in any state other than WR_WAIT, RD_CAPTURE or RD_WAIT is ignored.

## Timing
- Reset values: state=IDLE, cfg_ready=1, sr_din=0, sr_start=0, busy=0, done=0, pass=0, timeout=0, retries=0, capture register=0.
- Reset asserted mid-operation returns to IDLE immediately. sr_start drops asynchronously, and no done pulse is issued.
- Handshake at edge N: busy=1 and cfg_ready=0 from N. sr_start=1 in the cycle following N+1.
- sr_load sampled high at edge M in WR_WAIT: sr_start=1 in cycle M+1 to M+2, for the read pass.
- The WIDTH-th sr_clk edge sampled at edge K (RD_CAPTURE): the state is RD_WAIT from K.
- sr_load sampled high in RD_WAIT at edge L: the state is CHECK from L and DONE from L+1.
  - done is high for exactly one cycle, with pass, timeout and retries already final.
  - cfg_ready returns high one cycle after done.
- Minimum gap between two accepted words is 1 idle cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Nominal: cfg_din={1'b1,169'b1011}, engine model echoes its previous content. Required: two sr_start pulses, done, pass=1, retries=0, timeout=0.
- Single corruption: the model flips read-back bit 0 on the first verify only. Required: four sr_start pulses, pass=1, retries=1.
- Persistent mismatch, MAX_RETRY=3: the model stuck-at-0 on sr_dout. Required: eight sr_start pulses, pass=0, retries=3, timeout=0.
- Watchdog: the model never asserts sr_load, TIMEOUT_CYC=64. Required: done exactly 64 cycles after WR_WAIT entry, timeout=1, pass=0.
- Short read: sr_load arrives after 100 sr_clk edges. Required: mismatch path taken and retry issued.
- Reset mid-RD_CAPTURE, with cfg_valid held high throughout: rst low for 2 cycles. Required: all outputs at reset values, no done pulse. A new word is accepted on the first edge after rst rises.
